mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, memory word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, memory data width.
REQ-003 SHALL have parameter STARVE_MAX, default 3, denied-cycle limit for fetch before forced grant.
REQ-004 SHALL have one clock; reset is asynchronous and active-high; ports clk and reset.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  asynchronous active-high reset.
REQ-007 ir_req / ir_addr  input  1 / ADDR_W  instruction-fetch read request and address.
REQ-008 ir_gnt / ir_rvalid / ir_rdata  output  1 / 1 / DATA_W  fetch grant pulse, read-data valid pulse, read data.
REQ-009 ld_req / ld_addr  input  1 / ADDR_W  load read request and address.
REQ-010 ld_gnt / ld_rvalid / ld_rdata  output  1 / 1 / DATA_W  load grant, read-data valid, read data.
REQ-011 st_req / st_addr / st_wdata  input  1 / ADDR_W / DATA_W  store write request, address, data.
REQ-012 st_gnt  output  1  store grant pulse; write is issued in that cycle.
REQ-013 mem_en / mem_we  output  1 / 1  single-port memory command strobe and write enable.
REQ-014 mem_addr / mem_wdata  output  ADDR_W / DATA_W  memory command address and write data.
REQ-015 mem_ready  input  1  memory can accept a command this cycle.
REQ-016 mem_rvalid / mem_rdata  input  1 / DATA_W  memory read-data return, one or more cycles after the read command.
REQ-017 fetch_stall  output  1  ir_req high and ir_gnt low this cycle.
REQ-018 protocol_err  output  1  sticky flag: mem_rvalid seen with no read outstanding.

Function
REQ-019 SHALL implement FSM states IDLE and RD_WAIT; at most one read outstanding.
REQ-020 Issue SHALL occur only in IDLE with mem_ready=1, at least one req high, and mem_rvalid=0.
REQ-021 Priority SHALL be store > load > fetch, except fetch SHALL win when starve_cnt == STARVE_MAX.
REQ-022 On issue: exactly one gnt high; mem_en=1; mem_addr/mem_wdata/mem_we from winner. gnt and mem_* SHALL be combinational from state and inputs (same cycle).
REQ-023 Store issue: mem_we=1, state stays IDLE; back-to-back issues allowed next cycle.
REQ-024 Read issue: mem_we=0, mem_wdata=0; owner (IR or LD) latched; state -> RD_WAIT.
REQ-025 In RD_WAIT: no gnt, mem_en=0; on mem_rvalid=1 capture mem_rdata into owner's rdata register, pulse owner rvalid one cycle later (registered), state -> IDLE.
REQ-026 rdata registers SHALL hold last value until the next return to the same owner.
REQ-027 starve_cnt (width clog2(STARVE_MAX+1)): +1 per cycle where ir_req=1 and ir_gnt=0 while another requester is granted; clears when ir_gnt=1 or ir_req=0; saturates at STARVE_MAX.
REQ-028 Requesters SHALL hold req/addr/wdata stable until gnt; gnt is a single-cycle pulse per request.
REQ-029 mem_rvalid in IDLE SHALL be ignored for data and SHALL set protocol_err; no rvalid pulse.
REQ-030 mem_ready=0 in IDLE SHALL block issue; starve_cnt unchanged.
REQ-031 mem_rvalid in the same cycle as a pending req: return handled, issue deferred to next cycle.

Reset
REQ-032 reset SHALL force: state IDLE, owner cleared, starve_cnt 0, ir/ld_rvalid 0, ir/ld_rdata 0, protocol_err 0; all gnt and mem_en 0 while reset high.
REQ-033 Reset during RD_WAIT SHALL drop the outstanding read; a late mem_rvalid after reset sets protocol_err.

Verification
REQ-034 st_req, ld_req, ir_req all high from reset release, mem_ready=1, read latency 1 -> st_gnt cycle 0, ld_gnt cycle 1, ld_rvalid cycle 3, ir_gnt cycle 3.
REQ-035 ld_addr=0x005, mem_rdata=0xDEADBEEF returned 2 cycles after issue -> ld_rdata=0xDEADBEEF, ld_rvalid one cycle after mem_rvalid, ir_rvalid stays 0.
REQ-036 st_req held continuously with new data each grant, ir_req high, STARVE_MAX=3 -> stores granted 3 consecutive cycles, then ir_gnt, fetch_stall low only on that cycle.
REQ-037 mem_ready=0 for 4 cycles with ir_req high -> no gnt, mem_en 0, fetch_stall 1; grant on first cycle mem_ready=1.
REQ-038 reset asserted in RD_WAIT, mem_rvalid one cycle after release -> no rvalid pulse, protocol_err=1 until next reset.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for store, load and instruction-fetch requesters.
// One read outstanding at a time; fetch is force-granted after STARVE_MAX lost cycles.
module mem_port_arbiter #(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ir_req,
  input  logic [ADDR_W-1:0] ir_addr,
  output logic              ir_gnt,
  output logic              ir_rvalid,
  output logic [DATA_W-1:0] ir_rdata,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [DATA_W-1:0] ld_rdata,
  input  logic              st_req,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_wdata,
  output logic              st_gnt,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              fetch_stall,
  output logic              protocol_err
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic {IDLE, RD_WAIT} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IR, OWN_LD} owner_t;

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic              ir_rvalid_q, ir_rvalid_d;
  logic              ld_rvalid_q, ld_rvalid_d;
  logic [DATA_W-1:0] ir_rdata_q, ir_rdata_d;
  logic [DATA_W-1:0] ld_rdata_q, ld_rdata_d;
  logic              protocol_err_q, protocol_err_d;
  logic              issue;
  logic              fetch_forced;

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    starve_d       = starve_q;
    ir_rvalid_d    = 1'b0;
    ld_rvalid_d    = 1'b0;
    ir_rdata_d     = ir_rdata_q;
    ld_rdata_d     = ld_rdata_q;
    protocol_err_d = protocol_err_q;
    ir_gnt         = 1'b0;
    ld_gnt         = 1'b0;
    st_gnt         = 1'b0;
    mem_en         = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;

    // A returning read in the same cycle blocks issue; reset holds every grant low.
    issue        = (state_q == IDLE) && !reset && mem_ready && !mem_rvalid
                   && (ir_req || ld_req || st_req);
    fetch_forced = ir_req && (starve_q == STARVE_LIM);

    if (issue) begin
      mem_en = 1'b1;
      if (fetch_forced || (!st_req && !ld_req)) begin
        ir_gnt   = 1'b1;
        mem_addr = ir_addr;
        state_d  = RD_WAIT;
        owner_d  = OWN_IR;
      end else if (st_req) begin
        st_gnt    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = st_addr;
        mem_wdata = st_wdata;
      end else begin
        ld_gnt   = 1'b1;
        mem_addr = ld_addr;
        state_d  = RD_WAIT;
        owner_d  = OWN_LD;
      end
    end

    case (state_q)
      IDLE: begin
        if (mem_rvalid) protocol_err_d = 1'b1;
      end
      RD_WAIT: begin
        if (mem_rvalid) begin
          state_d = IDLE;
          owner_d = OWN_NONE;
          if (owner_q == OWN_IR) begin
            ir_rvalid_d = 1'b1;
            ir_rdata_d  = mem_rdata;
          end else if (owner_q == OWN_LD) begin
            ld_rvalid_d = 1'b1;
            ld_rdata_d  = mem_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (!ir_req || ir_gnt) begin
      starve_d = '0;
    end else if ((st_gnt || ld_gnt) && (starve_q != STARVE_LIM)) begin
      starve_d = starve_q + 1'b1;
    end

    fetch_stall = ir_req && !ir_gnt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      owner_q        <= OWN_NONE;
      starve_q       <= '0;
      ir_rvalid_q    <= 1'b0;
      ld_rvalid_q    <= 1'b0;
      ir_rdata_q     <= '0;
      ld_rdata_q     <= '0;
      protocol_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      starve_q       <= starve_d;
      ir_rvalid_q    <= ir_rvalid_d;
      ld_rvalid_q    <= ld_rvalid_d;
      ir_rdata_q     <= ir_rdata_d;
      ld_rdata_q     <= ld_rdata_d;
      protocol_err_q <= protocol_err_d;
    end
  end

  assign ir_rvalid    = ir_rvalid_q;
  assign ld_rvalid    = ld_rvalid_q;
  assign ir_rdata     = ir_rdata_q;
  assign ld_rdata     = ld_rdata_q;
  assign protocol_err = protocol_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by random traffic,
// all outputs compared each cycle against a transaction-level reference model.
module tb_mem_port_arbiter;
  localparam int AW = 11;
  localparam int DW = 32;
  localparam int SM = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          ir_req, ld_req, st_req;
  logic [AW-1:0] ir_addr, ld_addr, st_addr;
  logic [DW-1:0] st_wdata;
  logic          ir_gnt, ld_gnt, st_gnt;
  logic          ir_rvalid, ld_rvalid;
  logic [DW-1:0] ir_rdata, ld_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready, mem_rvalid;
  logic [DW-1:0] mem_rdata;
  logic          fetch_stall, protocol_err;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // reference model state
  bit            m_busy;
  int            m_owner;   // 0 none, 1 fetch, 2 load
  int            m_starve;
  bit            m_ir_rv, m_ld_rv, m_perr;
  logic [DW-1:0] m_ir_rd, m_ld_rd;
  bit            g_ir, g_ld, g_st, x_read;
  logic [AW-1:0] x_addr;

  // random-phase memory environment
  logic [DW-1:0] memarr [16];
  bit            rd_pend;
  int            rd_lat;
  logic [DW-1:0] rd_data;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
    .clk(clk), .reset(reset),
    .ir_req(ir_req), .ir_addr(ir_addr), .ir_gnt(ir_gnt), .ir_rvalid(ir_rvalid), .ir_rdata(ir_rdata),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
    .st_req(st_req), .st_addr(st_addr), .st_wdata(st_wdata), .st_gnt(st_gnt),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .fetch_stall(fetch_stall), .protocol_err(protocol_err)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Compare this cycle's outputs with the model, then advance the model one cycle.
  task automatic model_step();
    bit            iss, e_ir, e_ld, e_st, n_ir_rv, n_ld_rv;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    e_ir = 0; e_ld = 0; e_st = 0;
    if (reset) begin
      check_eq("rst_gnt", {ir_gnt, ld_gnt, st_gnt, mem_en}, 4'b0);
      check_eq("rst_rvalid", {ir_rvalid, ld_rvalid}, 2'b0);
      check_eq("rst_rdata", {ir_rdata, ld_rdata}, 64'h0);
      check_eq("rst_perr", protocol_err, 1'b0);
      check_eq("rst_stall", fetch_stall, ir_req);
      m_busy = 0; m_owner = 0; m_starve = 0; m_ir_rv = 0; m_ld_rv = 0;
      m_ir_rd = '0; m_ld_rd = '0; m_perr = 0;
      g_ir = 0; g_ld = 0; g_st = 0; x_read = 0;
      return;
    end
    iss = !m_busy && mem_ready && !mem_rvalid && (ir_req || ld_req || st_req);
    if (iss) begin
      if (ir_req && m_starve == SM) e_ir = 1;
      else if (st_req)              e_st = 1;
      else if (ld_req)              e_ld = 1;
      else                          e_ir = 1;
    end
    e_addr = e_st ? st_addr : (e_ld ? ld_addr : ir_addr);
    e_wd   = e_st ? st_wdata : '0;
    check_eq("ir_gnt", ir_gnt, e_ir);
    check_eq("ld_gnt", ld_gnt, e_ld);
    check_eq("st_gnt", st_gnt, e_st);
    check_eq("mem_en", mem_en, iss);
    if (iss) begin
      check_eq("mem_we", mem_we, e_st);
      check_eq("mem_addr", mem_addr, e_addr);
      check_eq("mem_wdata", mem_wdata, e_wd);
    end
    check_eq("fetch_stall", fetch_stall, ir_req && !e_ir);
    check_eq("ir_rvalid", ir_rvalid, m_ir_rv);
    check_eq("ld_rvalid", ld_rvalid, m_ld_rv);
    check_eq("ir_rdata", ir_rdata, m_ir_rd);
    check_eq("ld_rdata", ld_rdata, m_ld_rd);
    check_eq("protocol_err", protocol_err, m_perr);

    if (!ir_req || e_ir) m_starve = 0;
    else if ((e_st || e_ld) && m_starve < SM) m_starve = m_starve + 1;
    n_ir_rv = m_busy && mem_rvalid && m_owner == 1;
    n_ld_rv = m_busy && mem_rvalid && m_owner == 2;
    if (n_ir_rv) m_ir_rd = mem_rdata;
    if (n_ld_rv) m_ld_rd = mem_rdata;
    m_ir_rv = n_ir_rv;
    m_ld_rv = n_ld_rv;
    if (!m_busy && mem_rvalid) m_perr = 1;
    if (m_busy && mem_rvalid) begin
      m_busy = 0; m_owner = 0;
    end
    if (e_ir || e_ld) begin
      m_busy = 1; m_owner = e_ir ? 1 : 2;
    end
    g_ir = e_ir; g_ld = e_ld; g_st = e_st;
    x_read = e_ir || e_ld; x_addr = e_addr;
  endtask

  task automatic eval_cycle();
    #4;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic end_cycle();
    model_step();
    advance();
  endtask

  initial begin
    reset = 1'b1;
    ir_req = 0; ld_req = 0; st_req = 0;
    ir_addr = '0; ld_addr = '0; st_addr = '0; st_wdata = '0;
    mem_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;
    rd_pend = 0; rd_lat = 0; rd_data = '0;
    for (int i = 0; i < 16; i++) memarr[i] = $urandom;
    advance();

    // all three requesting from reset release, read latency 1
    st_req = 1; ld_req = 1; ir_req = 1;
    st_addr = 11'h010; st_wdata = 32'hA5A5_0001; ld_addr = 11'h020; ir_addr = 11'h030;
    eval_cycle(); end_cycle();
    reset = 1'b0;
    eval_cycle();
    check_eq("r034_st_c0", st_gnt, 1'b1);
    check_eq("r034_we_c0", mem_we, 1'b1);
    end_cycle();
    st_req = 0;
    eval_cycle();
    check_eq("r034_ld_c1", ld_gnt, 1'b1);
    end_cycle();
    ld_req = 0; mem_rvalid = 1; mem_rdata = 32'h1111_2222;
    eval_cycle();
    check_eq("r034_wait_c2", {ir_gnt, ld_gnt, mem_en}, 3'b0);
    end_cycle();
    mem_rvalid = 0; mem_rdata = 32'h0BAD_0BAD;
    eval_cycle();
    check_eq("r034_ldrv_c3", ld_rvalid, 1'b1);
    check_eq("r034_irgnt_c3", ir_gnt, 1'b1);
    check_eq("r034_ldrd_c3", ld_rdata, 32'h1111_2222);
    end_cycle();
    ir_req = 0; mem_rvalid = 1; mem_rdata = 32'h3333_4444;
    eval_cycle(); end_cycle();
    mem_rvalid = 0;
    eval_cycle();
    check_eq("r034_irrv", ir_rvalid, 1'b1);
    check_eq("r034_irrd", ir_rdata, 32'h3333_4444);
    end_cycle();

    // load with 2-cycle return latency
    ld_req = 1; ld_addr = 11'h005;
    eval_cycle();
    check_eq("r035_gnt", ld_gnt, 1'b1);
    check_eq("r035_addr", mem_addr, 11'h005);
    end_cycle();
    ld_req = 0;
    eval_cycle(); end_cycle();
    mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF;
    eval_cycle();
    check_eq("r035_rv_early", ld_rvalid, 1'b0);
    end_cycle();
    mem_rvalid = 0; mem_rdata = 32'h1234_5678;
    eval_cycle();
    check_eq("r035_rv", ld_rvalid, 1'b1);
    check_eq("r035_rd", ld_rdata, 32'hDEAD_BEEF);
    check_eq("r035_irrv", ir_rvalid, 1'b0);
    end_cycle();
    eval_cycle();
    check_eq("r035_rv_pulse", ld_rvalid, 1'b0);
    check_eq("r035_rd_hold", ld_rdata, 32'hDEAD_BEEF);
    end_cycle();

    // fetch starvation with continuous stores
    ir_req = 1; ir_addr = 11'h007; st_req = 1;
    for (int i = 0; i < 3; i++) begin
      st_addr = AW'(i); st_wdata = $urandom;
      eval_cycle();
      check_eq("r036_st", st_gnt, 1'b1);
      check_eq("r036_stall", fetch_stall, 1'b1);
      end_cycle();
    end
    st_addr = 11'h003; st_wdata = $urandom;
    eval_cycle();
    check_eq("r036_irgnt", ir_gnt, 1'b1);
    check_eq("r036_stgnt", st_gnt, 1'b0);
    check_eq("r036_nostall", fetch_stall, 1'b0);
    end_cycle();
    ir_req = 0; st_req = 0; mem_rvalid = 1; mem_rdata = 32'hCAFE_F00D;
    eval_cycle(); end_cycle();
    mem_rvalid = 0;
    eval_cycle();
    check_eq("r036_irrv", ir_rvalid, 1'b1);
    end_cycle();

    // memory not ready blocks issue
    ir_req = 1; ir_addr = 11'h044; mem_ready = 0;
    for (int i = 0; i < 4; i++) begin
      eval_cycle();
      check_eq("r037_blocked", {ir_gnt, mem_en, fetch_stall}, 3'b001);
      end_cycle();
    end
    mem_ready = 1;
    eval_cycle();
    check_eq("r037_gnt", ir_gnt, 1'b1);
    end_cycle();
    ir_req = 0; mem_rvalid = 1; mem_rdata = 32'h0000_0044;
    eval_cycle(); end_cycle();
    mem_rvalid = 0;
    eval_cycle(); end_cycle();

    // reset while a read is outstanding; the late return is a protocol error
    ld_req = 1; ld_addr = 11'h066;
    eval_cycle();
    check_eq("r038_gnt", ld_gnt, 1'b1);
    end_cycle();
    ld_req = 0; reset = 1;
    eval_cycle(); end_cycle();
    reset = 0;
    eval_cycle(); end_cycle();
    mem_rvalid = 1; mem_rdata = 32'h7777_7777;
    eval_cycle(); end_cycle();
    mem_rvalid = 0;
    for (int i = 0; i < 3; i++) begin
      eval_cycle();
      check_eq("r038_perr", protocol_err, 1'b1);
      check_eq("r038_norv", {ir_rvalid, ld_rvalid}, 2'b0);
      end_cycle();
    end
    reset = 1;
    eval_cycle();
    check_eq("r038_perr_clr", protocol_err, 1'b0);
    end_cycle();
    reset = 0;

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      if (!ir_req || g_ir) begin
        ir_req = ($urandom_range(0, 2) != 0); ir_addr = AW'($urandom_range(0, 15));
      end
      if (!ld_req || g_ld) begin
        ld_req = ($urandom_range(0, 1) == 1); ld_addr = AW'($urandom_range(0, 15));
      end
      if (!st_req || g_st) begin
        st_req = ($urandom_range(0, 3) == 0); st_addr = AW'($urandom_range(0, 15));
        st_wdata = $urandom;
      end
      mem_ready = ($urandom_range(0, 3) != 0);
      if (rd_pend && rd_lat == 0) begin
        mem_rvalid = 1; mem_rdata = rd_data; rd_pend = 0;
      end else begin
        if (rd_pend) rd_lat--;
        mem_rvalid = 0; mem_rdata = $urandom;
      end
      eval_cycle();
      model_step();
      if (x_read) begin
        rd_pend = 1; rd_lat = $urandom_range(0, 2); rd_data = memarr[x_addr[3:0]];
      end
      if (g_st) memarr[st_addr[3:0]] = st_wdata;
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
